// File: rtl/e_clk_pkg.sv
// Shared definitions for the 6809 E/Q phase tracker: bus quadrant encoding,
// tracker FSM state and the edge that legally advances each quadrant.
package e_clk_pkg;

    localparam logic [1:0] PH_E0Q0 = 2'd0;
    localparam logic [1:0] PH_E0Q1 = 2'd1;
    localparam logic [1:0] PH_E1Q1 = 2'd2;
    localparam logic [1:0] PH_E1Q0 = 2'd3;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    // Edge vectors are ordered {q_fall, q_rise, e_fall, e_rise}.
    function automatic logic [3:0] advance_edge(input logic [1:0] phase);
        case (phase)
            PH_E0Q0: advance_edge = 4'b0100;
            PH_E0Q1: advance_edge = 4'b0001;
            PH_E1Q1: advance_edge = 4'b1000;
            PH_E1Q0: advance_edge = 4'b0010;
            default: advance_edge = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous level, followed by a registered
// rise/fall detector producing single-cycle pulses.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: flops use non-blocking assignments so every stage samples the
    // value its neighbour held before the edge; blocking would collapse the chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
            prev_q <= sync_q[SYNC_STAGES-1];
            o_rise <= sync_q[SYNC_STAGES-1] & ~prev_q;
            o_fall <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign o_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/e_q_phase_tracker.sv
// Tracks the 6809 E/Q bus quadrant, measures the E period and flags a lost E
// clock. o_e_fall is the qualified strobe used by the downstream E-delay stage.
module e_q_phase_tracker #(
    parameter int SYNC_STAGES    = 2,
    parameter int PERIOD_W       = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_e_clk,
    input  logic                i_q_clk,
    output logic                o_e_sync,
    output logic                o_q_sync,
    output logic                o_e_rise,
    output logic                o_e_fall,
    output logic                o_q_rise,
    output logic                o_q_fall,
    output logic [1:0]          o_phase,
    output logic                o_locked,
    output logic                o_seq_err,
    output logic [PERIOD_W-1:0] o_period,
    output logic                o_period_valid,
    output logic                o_clk_lost
);

    import e_clk_pkg::*;

    localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
    localparam logic [PERIOD_W-1:0] IDLE_MAX  = PERIOD_W'(TIMEOUT_CYCLES);
    localparam logic [PERIOD_W-1:0] IDLE_LAST = PERIOD_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic                seq_err_d;
    logic [3:0]          edges;
    logic                e_edge;
    logic                timeout;
    logic                seen_fall_q;
    logic [PERIOD_W-1:0] period_cnt_q;
    logic [PERIOD_W-1:0] idle_cnt_q;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_e_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_e_clk),
        .o_sync  (o_e_sync),
        .o_rise  (o_e_rise),
        .o_fall  (o_e_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_q_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_q_clk),
        .o_sync  (o_q_sync),
        .o_rise  (o_q_rise),
        .o_fall  (o_q_fall)
    );

    assign edges   = {o_q_fall, o_q_rise, o_e_fall, o_e_rise};
    assign e_edge  = o_e_rise | o_e_fall;
    // Any E edge resets the idle count, so a coinciding e_fall always beats the timeout.
    assign timeout = !e_edge && (idle_cnt_q == IDLE_LAST);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        seq_err_d = 1'b0;
        if (timeout) begin
            state_d = UNLOCKED;
            phase_d = PH_E0Q0;
        end else if (state_q == UNLOCKED) begin
            phase_d = PH_E0Q0;
            if (o_e_fall && !o_q_sync) begin
                state_d = LOCKED;
            end
        end else if (edges != 4'b0000) begin
            if (edges == advance_edge(phase_q)) begin
                phase_d = phase_q + 2'd1;
            end else begin
                seq_err_d = 1'b1;
                state_d   = UNLOCKED;
                phase_d   = PH_E0Q0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= UNLOCKED;
            phase_q   <= PH_E0Q0;
            o_seq_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            o_seq_err <= seq_err_d;
        end
    end

    assign o_locked = (state_q == LOCKED);
    assign o_phase  = phase_q;

    // A period is only published once a previous e_fall anchors the measurement.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            period_cnt_q   <= '0;
            idle_cnt_q     <= '0;
            seen_fall_q    <= 1'b0;
            o_period       <= '0;
            o_period_valid <= 1'b0;
            o_clk_lost     <= 1'b0;
        end else begin
            if (o_e_fall) begin
                period_cnt_q <= PERIOD_W'(1);
            end else if (period_cnt_q != CNT_MAX) begin
                period_cnt_q <= period_cnt_q + 1'b1;
            end

            if (e_edge) begin
                idle_cnt_q <= '0;
            end else if (idle_cnt_q != IDLE_MAX) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end

            if (timeout) begin
                o_clk_lost     <= 1'b1;
                seen_fall_q    <= 1'b0;
                o_period_valid <= 1'b0;
            end else if (o_e_fall) begin
                o_clk_lost  <= 1'b0;
                seen_fall_q <= 1'b1;
                if (seen_fall_q) begin
                    o_period       <= period_cnt_q;
                    o_period_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_e_q_phase_tracker.sv
// Randomized self-checking bench for e_q_phase_tracker against a cycle-level
// model built from pin history and the quadrant/period/timeout rules.
module tb_e_q_phase_tracker;

    localparam int S2      = 2;
    localparam int S3      = 3;
    localparam int TIMEOUT = 200;
    localparam int PMAX    = 255;

    logic       i_clk;
    logic       i_rst_n;
    logic       e_pin;
    logic       q_pin;

    logic       o_e_sync, o_q_sync, o_e_rise, o_e_fall, o_q_rise, o_q_fall;
    logic [1:0] o_phase;
    logic       o_locked, o_seq_err, o_period_valid, o_clk_lost;
    logic [7:0] o_period;

    logic       e_sync3, q_sync3, e_rise3, e_fall3, q_rise3, q_fall3;
    logic [1:0] phase3;
    logic       locked3, seq_err3, period_valid3, clk_lost3;
    logic [7:0] period3;

    int n_checks = 0;
    int n_errors = 0;
    int seq_seen = 0;
    int lost_low = 0;

    // Reference model state
    bit         h_e[$];
    bit         h_q[$];
    int         cyc;
    int         last_e_cyc;
    int         last_fall;
    bit         m_locked, m_seq_err, m_valid, m_lost, m_seen;
    logic [1:0] m_phase;
    logic [7:0] m_period;

    e_q_phase_tracker dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_e_clk        (e_pin),
        .i_q_clk        (q_pin),
        .o_e_sync       (o_e_sync),
        .o_q_sync       (o_q_sync),
        .o_e_rise       (o_e_rise),
        .o_e_fall       (o_e_fall),
        .o_q_rise       (o_q_rise),
        .o_q_fall       (o_q_fall),
        .o_phase        (o_phase),
        .o_locked       (o_locked),
        .o_seq_err      (o_seq_err),
        .o_period       (o_period),
        .o_period_valid (o_period_valid),
        .o_clk_lost     (o_clk_lost)
    );

    e_q_phase_tracker #(.SYNC_STAGES(S3)) dut3 (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_e_clk        (e_pin),
        .i_q_clk        (q_pin),
        .o_e_sync       (e_sync3),
        .o_q_sync       (q_sync3),
        .o_e_rise       (e_rise3),
        .o_e_fall       (e_fall3),
        .o_q_rise       (q_rise3),
        .o_q_fall       (q_fall3),
        .o_phase        (phase3),
        .o_locked       (locked3),
        .o_seq_err      (seq_err3),
        .o_period       (period3),
        .o_period_valid (period_valid3),
        .o_clk_lost     (clk_lost3)
    );

    logic [19:0] dut_vec;
    logic [5:0]  dut3_vec;
    assign dut_vec  = {o_e_sync, o_q_sync, o_e_rise, o_e_fall, o_q_rise, o_q_fall,
                       o_phase, o_locked, o_seq_err, o_period, o_period_valid, o_clk_lost};
    assign dut3_vec = {e_sync3, q_sync3, e_rise3, e_fall3, q_rise3, q_fall3};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Synced level is the pin S samples back; a pulse marks a change one sample later.
    function automatic logic [5:0] edge_vec(input int s);
        return {h_e[s-1], h_q[s-1],
                h_e[s] & ~h_e[s+1], ~h_e[s] & h_e[s+1],
                h_q[s] & ~h_q[s+1], ~h_q[s] & h_q[s+1]};
    endfunction

    function automatic logic [19:0] exp_vec();
        return {edge_vec(S2), m_phase, m_locked, m_seq_err, m_period, m_valid, m_lost};
    endfunction

    task automatic model_reset();
        h_e = {};
        h_q = {};
        for (int i = 0; i < 8; i++) begin
            h_e.push_front(1'b0);
            h_q.push_front(1'b0);
        end
        cyc = 0; last_e_cyc = 0; last_fall = 0;
        m_locked = 0; m_seq_err = 0; m_valid = 0; m_lost = 0; m_seen = 0;
        m_phase = 2'd0; m_period = 8'd0;
    endtask

    task automatic model_step();
        bit er, ef, qr, qf, qs, ok, tmo;
        int nedge, d;
        // Pulses visible during the cycle that this clock edge closes
        er = h_e[S2] & ~h_e[S2+1];
        ef = ~h_e[S2] & h_e[S2+1];
        qr = h_q[S2] & ~h_q[S2+1];
        qf = ~h_q[S2] & h_q[S2+1];
        qs = h_q[S2-1];
        cyc++;
        tmo = !(er || ef) && (cyc - last_e_cyc == TIMEOUT);
        if (er || ef) last_e_cyc = cyc;
        nedge = int'(er) + int'(ef) + int'(qr) + int'(qf);

        m_seq_err = 0;
        if (tmo) begin
            m_locked = 0;
            m_phase  = 2'd0;
        end else if (!m_locked) begin
            m_phase = 2'd0;
            if (ef && !qs) m_locked = 1;
        end else if (nedge != 0) begin
            ok = (nedge == 1) &&
                 ((m_phase == 2'd0 && qr) || (m_phase == 2'd1 && er) ||
                  (m_phase == 2'd2 && qf) || (m_phase == 2'd3 && ef));
            if (ok) begin
                m_phase = m_phase + 2'd1;
            end else begin
                m_seq_err = 1;
                m_locked  = 0;
                m_phase   = 2'd0;
            end
        end

        if (tmo) begin
            m_lost = 1; m_seen = 0; m_valid = 0;
        end else if (ef) begin
            m_lost = 0;
            if (m_seen) begin
                d        = cyc - last_fall;
                m_period = (d > PMAX) ? 8'hFF : 8'(d);
                m_valid  = 1;
            end
            m_seen    = 1;
            last_fall = cyc;
        end

        h_e.push_front(e_pin);
        h_q.push_front(q_pin);
        void'(h_e.pop_back());
        void'(h_q.pop_back());
    endtask

    task automatic tick(input logic e, input logic q);
        #($urandom_range(0, 3));
        e_pin = e;
        q_pin = q;
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        check("outs", 32'(dut_vec), 32'(exp_vec()));
        check("sync3", 32'(dut3_vec), 32'(edge_vec(S3)));
        if (o_seq_err) seq_seen++;
        if (!o_clk_lost) lost_low++;
    endtask

    // Q leads E by a quarter period: E0Q0, E0Q1, E1Q1, E1Q0.
    function automatic logic [1:0] wave(input int t, input int p);
        logic e, q;
        e = (t >= p / 2);
        q = (t >= p / 4) && (t < (3 * p) / 4);
        return {e, q};
    endfunction

    task automatic run_periods(input int p, input int n);
        logic [1:0] w;
        for (int k = 0; k < n; k++) begin
            for (int t = 0; t < p; t++) begin
                w = wave(t, p);
                tick(w[1], w[0]);
            end
        end
    endtask

    task automatic do_reset();
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_outs", 32'(dut_vec), 32'd0);
        check("rst_sync3", 32'(dut3_vec), 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] w;
        logic       ev, qv, p2, p3;
        int         lat2, lat3, w2, w3, base;

        i_rst_n = 1'b1;
        e_pin   = 1'b0;
        q_pin   = 1'b0;
        @(negedge i_clk);
        do_reset();

        // Synchronizer latency and pulse width for both depths
        ev = 1'b0; qv = 1'b0;
        repeat (4) tick(ev, qv);
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: ev = 1'b1;
                1: qv = 1'b1;
                2: ev = 1'b0;
                default: qv = 1'b0;
            endcase
            lat2 = 0; lat3 = 0; w2 = 0; w3 = 0;
            for (int j = 1; j <= 8; j++) begin
                tick(ev, qv);
                case (s)
                    0: begin p2 = o_e_rise; p3 = e_rise3; end
                    1: begin p2 = o_q_rise; p3 = q_rise3; end
                    2: begin p2 = o_e_fall; p3 = e_fall3; end
                    default: begin p2 = o_q_fall; p3 = q_fall3; end
                endcase
                if (p2) begin w2++; if (lat2 == 0) lat2 = j; end
                if (p3) begin w3++; if (lat3 == 0) lat3 = j; end
            end
            check("lat2", 32'(lat2), 32'(S2 + 1));
            check("lat3", 32'(lat3), 32'(S3 + 1));
            check("wid2", 32'(w2), 32'd1);
            check("wid3", 32'(w3), 32'd1);
        end

        // 1 MHz E at 100 MHz: lock on first e_fall, period 100 from the second
        do_reset();
        run_periods(100, 1);
        check("prelock", 32'(o_locked), 32'd0);
        run_periods(100, 4);
        check("locked", 32'(o_locked), 32'd1);
        check("p100", 32'(o_period), 32'd100);
        check("pvalid", 32'(o_period_valid), 32'd1);

        // E and Q toggle in the same cycle while locked
        base = seq_seen;
        for (int t = 0; t < 25; t++) begin w = wave(t, 100); tick(w[1], w[0]); end
        for (int t = 50; t < 60; t++) begin w = wave(t, 100); tick(w[1], w[0]); end
        check("unlock", 32'(o_locked), 32'd0);
        for (int t = 60; t < 100; t++) begin w = wave(t, 100); tick(w[1], w[0]); end
        run_periods(100, 2);
        check("seqerr_n", 32'(seq_seen - base), 32'd1);
        check("relock", 32'(o_locked), 32'd1);

        // E stuck high: loss 200 cycles after the last E edge is consumed
        lost_low = 0;
        for (int h = 0; h < 250; h++) tick(1'b1, 1'b0);
        check("lost_at", 32'(lost_low), 32'(50 + S2 + 1 + TIMEOUT - 100));
        check("lost", 32'(o_clk_lost), 32'd1);
        check("lost_val", 32'(o_period_valid), 32'd0);
        check("lost_lck", 32'(o_locked), 32'd0);
        run_periods(100, 1);
        check("lost_clr", 32'(o_clk_lost), 32'd0);
        check("relock2", 32'(o_locked), 32'd1);
        check("val_wait", 32'(o_period_valid), 32'd0);
        run_periods(100, 1);
        check("p100b", 32'(o_period), 32'd100);
        check("pvalidb", 32'(o_period_valid), 32'd1);

        // 300-cycle period saturates the 8-bit measurement
        run_periods(300, 3);
        check("psat", 32'(o_period), 32'd255);
        check("psat_v", 32'(o_period_valid), 32'd1);

        // Randomized periods, random pin noise, idle spell, then recovery
        for (int k = 0; k < 10; k++) run_periods(int'($urandom_range(6, 140)), 1);
        ev = e_pin; qv = q_pin;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 7) == 0) ev = ~ev;
            if ($urandom_range(0, 7) == 0) qv = ~qv;
            tick(ev, qv);
        end
        for (int k = 0; k < 220; k++) tick(ev, qv);
        for (int k = 0; k < 8; k++) run_periods(int'($urandom_range(6, 140)), 1);

        // Reset mid-period discards the partial measurement
        run_periods(100, 1);
        for (int t = 0; t < 40; t++) begin w = wave(t, 100); tick(w[1], w[0]); end
        do_reset();
        run_periods(100, 1);
        for (int t = 0; t < 10; t++) begin w = wave(t, 100); tick(w[1], w[0]); end
        check("rlock", 32'(o_locked), 32'd1);
        check("rvalid", 32'(o_period_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
